// File: rtl/weight_buffer_pkg.sv
// weight_buffer_pkg: shared constants and types for the kernel weight buffer.
// Holds kernel word count, weight word type, ROM depth and base-advance helper.
package weight_buffer_pkg;

   localparam int KERNEL_SIZE  = 3;
   localparam int KERNEL_WORDS = KERNEL_SIZE * KERNEL_SIZE;
   localparam int ROM_AW       = 12;
   localparam int ROM_DEPTH    = 1 << ROM_AW;
   localparam int WORD_W       = 16;

   typedef logic signed [WORD_W-1:0] weight_t;

   // Next kernel base; wraps to 0 once the last stored kernel is passed.
   function automatic logic [ROM_AW-1:0] next_base(
      input logic [ROM_AW-1:0] base,
      input int                words,
      input int                num_kernels
   );
      logic [ROM_AW:0] sum;
      logic [ROM_AW:0] last;
      sum  = {1'b0, base} + (ROM_AW+1)'(words);
      last = (ROM_AW+1)'((num_kernels - 1) * words);
      next_base = (sum > last) ? '0 : sum[ROM_AW-1:0];
   endfunction

endpackage

// File: rtl/weight_rom.sv
// weight_rom: sync-read weight ROM, 1-cycle.
// Image: word i holds i+1.
module weight_rom
  import weight_buffer_pkg::*;
#(
  parameter int AW            = 12,
  parameter int DW            = 16,
  parameter     INIT_FILE     = "weights.mem",
  parameter bit USE_INIT_FILE = 1'b1
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [1 << AW];

  initial begin
    for (int i = 0; i < (1 << AW); i++)
      mem[i] = DW'(i + 1);
  end

  always_ff @(posedge clk) begin
    if (en) q <= mem[addr];
  end

endmodule

// File: rtl/weight_buffer.sv
// weight_buffer: fetches one 3x3 kernel from weight_rom, presents it in parallel.
// Ports: clk, reset (async low), enable, change (next kernel), weight0..8, weight_OK.
module weight_buffer
   import weight_buffer_pkg::*;
#(
   parameter int KERNEL_SIZE           = 3,
   parameter int ROM_ADDRESS_DATAWIDTH = 12,
   parameter int COUNTER_DATAWIDTH     = 4,
   parameter int NUMBER_DATAWIDTH      = 16,
   parameter int NUM_KERNELS           = 16,
   parameter     INIT_FILE             = "weights.mem",
   parameter bit USE_INIT_FILE         = 1'b1
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    enable,
   input  logic    change,
   output weight_t weight0,
   output weight_t weight1,
   output weight_t weight2,
   output weight_t weight3,
   output weight_t weight4,
   output weight_t weight5,
   output weight_t weight6,
   output weight_t weight7,
   output weight_t weight8,
   output logic    weight_OK
);

   localparam int AW = ROM_ADDRESS_DATAWIDTH;
   localparam int CW = COUNTER_DATAWIDTH;
   localparam int NW = NUMBER_DATAWIDTH;
   localparam int KW = KERNEL_SIZE * KERNEL_SIZE;

   localparam logic [CW-1:0] KW_C   = CW'(KW);
   localparam logic [CW-1:0] LAST_C = CW'(KW - 1);

   logic [AW-1:0] base;
   logic [AW-1:0] rd_addr;
   logic [CW-1:0] issue_cnt;
   logic [CW-1:0] rd_idx;
   logic          rd_valid;
   logic          issue;
   logic [NW-1:0] rom_q;
   weight_t       w [KW];

   assign issue   = !change && enable && (issue_cnt < KW_C);
   assign rd_addr = base + AW'(issue_cnt);

   weight_rom #(
      .AW            (AW),
      .DW            (NW),
      .INIT_FILE     (INIT_FILE),
      .USE_INIT_FILE (USE_INIT_FILE)
   ) u_rom (
      .clk  (clk),
      .en   (issue),
      .addr (rd_addr),
      .q    (rom_q)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base      <= '0;
         issue_cnt <= '0;
         rd_idx    <= '0;
         rd_valid  <= 1'b0;
         weight_OK <= 1'b0;
         for (int i = 0; i < KW; i++) w[i] <= '0;
      end else if (change) begin
         // Any read still in flight belongs to the old kernel: drop it.
         base      <= next_base(base, KW, NUM_KERNELS);
         issue_cnt <= '0;
         rd_valid  <= 1'b0;
         weight_OK <= 1'b0;
      end else begin
         rd_valid <= issue;
         if (issue) begin
            rd_idx    <= issue_cnt;
            issue_cnt <= issue_cnt + 1'b1;
         end
         // An issued read always lands, even if enable dropped meanwhile.
         if (rd_valid) begin
            for (int i = 0; i < KW; i++) begin
               if (rd_idx == CW'(i)) w[i] <= weight_t'(rom_q);
            end
            if (rd_idx == LAST_C) weight_OK <= 1'b1;
         end
      end
   end

   assign weight0 = w[0];
   assign weight1 = w[1];
   assign weight2 = w[2];
   assign weight3 = w[3];
   assign weight4 = w[4];
   assign weight5 = w[5];
   assign weight6 = w[6];
   assign weight7 = w[7];
   assign weight8 = w[8];

endmodule

// File: tb/tb_weight_buffer.sv
// tb_weight_buffer: directed self-checking bench for weight_buffer.
// ROM uses the built-in image where word i holds i+1.
module tb_weight_buffer;
   import weight_buffer_pkg::*;

   logic    clk;
   logic    reset;
   logic    enable;
   logic    change;
   weight_t weight0, weight1, weight2, weight3, weight4;
   weight_t weight5, weight6, weight7, weight8;
   logic    weight_OK;

   weight_t wv [9];

   int checks   = 0;
   int failures = 0;

   weight_buffer #(
      .INIT_FILE     (""),
      .USE_INIT_FILE (1'b0)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .change    (change),
      .weight0   (weight0),
      .weight1   (weight1),
      .weight2   (weight2),
      .weight3   (weight3),
      .weight4   (weight4),
      .weight5   (weight5),
      .weight6   (weight6),
      .weight7   (weight7),
      .weight8   (weight8),
      .weight_OK (weight_OK)
   );

   assign wv[0] = weight0;
   assign wv[1] = weight1;
   assign wv[2] = weight2;
   assign wv[3] = weight3;
   assign wv[4] = weight4;
   assign wv[5] = weight5;
   assign wv[6] = weight6;
   assign wv[7] = weight7;
   assign wv[8] = weight8;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Kernel k holds ROM words 9k..9k+8, i.e. values 9k+1..9k+9.
   task automatic chk_kernel(input string tag, input int k);
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("%s_w%0d", tag, i), int'(wv[i]), 9 * k + i + 1);
      end
   endtask

   task automatic pulse_change(input logic en);
      change = 1'b1;
      enable = en;
      step(1);
      change = 1'b0;
   endtask

   initial begin
      reset  = 1'b0;
      enable = 1'b0;
      change = 1'b0;
      step(2);
      chk("rst_ok", int'(weight_OK), 0);
      chk("rst_w0", int'(weight0), 0);
      chk("rst_w8", int'(weight8), 0);

      // Plain load of kernel 0.
      reset  = 1'b1;
      enable = 1'b1;
      step(1);
      chk("k0_w0_e0", int'(weight0), 0);
      step(1);
      chk("k0_w0_e1", int'(weight0), 1);
      chk("k0_w1_e1", int'(weight1), 0);
      step(7);
      chk("k0_ok_e8", int'(weight_OK), 0);
      step(1);
      chk("k0_ok_e9", int'(weight_OK), 1);
      chk_kernel("k0", 0);

      // Change pulse then reload kernel 1.
      pulse_change(1'b1);
      chk("k1_ok_drop", int'(weight_OK), 0);
      chk("k1_w0_hold", int'(weight0), 1);
      step(9);
      chk("k1_ok_e8", int'(weight_OK), 0);
      step(1);
      chk("k1_ok_e9", int'(weight_OK), 1);
      chk_kernel("k1", 1);

      // Kernel 2 with enable low for 3 cycles mid-load.
      pulse_change(1'b1);
      step(4);
      enable = 1'b0;
      step(3);
      chk("k2_ok_pause", int'(weight_OK), 0);
      enable = 1'b1;
      step(5);
      chk("k2_ok_e11", int'(weight_OK), 0);
      step(1);
      chk("k2_ok_e12", int'(weight_OK), 1);
      chk_kernel("k2", 2);

      // Kernel 3 aborted at cnt=4, restart lands on kernel 4.
      pulse_change(1'b1);
      step(4);
      pulse_change(1'b1);
      chk("abort_ok", int'(weight_OK), 0);
      chk("abort_w2", int'(weight2), 30);
      chk("abort_w3", int'(weight3), 22);
      step(9);
      chk("k4_ok_e8", int'(weight_OK), 0);
      step(1);
      chk("k4_ok_e9", int'(weight_OK), 1);
      chk_kernel("k4", 4);

      // Periodic: change+enable every 15 cycles, enable low 1 cycle.
      for (int p = 5; p < 8; p++) begin
         pulse_change(1'b1);
         step(13);
         chk($sformatf("per%0d_ok", p), int'(weight_OK), 1);
         chk($sformatf("per%0d_w0", p), int'(weight0), 9 * p + 1);
         chk($sformatf("per%0d_w8", p), int'(weight8), 9 * p + 9);
         enable = 1'b0;
         step(1);
         chk($sformatf("per%0d_hold", p), int'(weight_OK), 1);
      end

      // Consecutive change pulses: kernel 7 -> 15, then wrap to 0.
      change = 1'b1;
      enable = 1'b1;
      step(8);
      change = 1'b0;
      chk("multi_ok", int'(weight_OK), 0);
      step(10);
      chk("k15_ok", int'(weight_OK), 1);
      chk("k15_w0", int'(weight0), 136);
      chk("k15_w8", int'(weight8), 144);
      pulse_change(1'b1);
      step(10);
      chk("wrap_ok", int'(weight_OK), 1);
      chk_kernel("wrap", 0);

      // Async reset mid-load of kernel 1.
      pulse_change(1'b1);
      step(4);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_ok", int'(weight_OK), 0);
      chk("arst_w0", int'(weight0), 0);
      chk("arst_w3", int'(weight3), 0);
      step(1);
      reset = 1'b1;
      step(10);
      chk("arst_reload_ok", int'(weight_OK), 1);
      chk_kernel("arst", 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
